// File: rtl/add_sequencer_pkg.sv
// Shared types for the add sequencer: state encoding and default datapath width.
package add_sequencer_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    ADD    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/key_pulse.sv
// Synchronises an active-low pushbutton and emits a one-cycle pulse per press.
// Pulse appears SYNC_STAGES clocks after the falling edge; no backpressure.
module key_pulse #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Reset loads "pressed" so a key held through reset must be released first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_n};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse = prev & ~sync[SYNC_STAGES-1];

endmodule

// File: rtl/add_sequencer.sv
// Button-stepped operand capture, one-cycle add, and result hold with optional accumulate.
// Result registered on the clock after the B capture; steps arriving during ADD are dropped.
module add_sequencer
  import add_sequencer_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   step_n,
  input  logic                   clear,
  input  logic                   mode_acc,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       op_a,
  output logic [WIDTH-1:0]       op_b,
  output logic [WIDTH-1:0]       sum,
  output logic                   carry_out,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] add_count,
  output logic [STATE_W-1:0]     state,
  output logic                   busy
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_t         st;
  logic           step;
  logic [WIDTH:0] add_full;

  key_pulse #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_key_pulse (
    .clock(clock),
    .reset(reset),
    .key_n(step_n),
    .pulse(step)
  );

  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign state    = st;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      add_count <= '0;
      busy      <= 1'b0;
    end else if (clear) begin
      st        <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      add_count <= '0;
      busy      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (step) begin
            op_a <= data_in;
            st   <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (step) begin
            op_b <= data_in;
            st   <= ADD;
            busy <= 1'b1;
          end
        end
        ADD: begin
          {carry_out, sum} <= add_full;
          overflow         <= overflow | add_full[WIDTH];
          if (add_count != COUNT_MAX)
            add_count <= add_count + COUNT_WIDTH'(1);
          st   <= DONE;
          busy <= 1'b0;
        end
        DONE: begin
          // Accumulate mode chains the held sum into A; op_b waits for the next capture.
          if (step) begin
            op_a <= mode_acc ? sum : data_in;
            st   <= WAIT_B;
          end
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
